memory_arbiter: RTL

Round-robin arbiter that shares the single system-side command port of `memory_ctrl` between `NUM_REQ` independent requesters. Each requester presents a read or write command; the arbiter selects one, issues it to the controller with a one-cycle `cmd_valid_sys` pulse, and waits for `ready_sys`. It then returns completion, and read data, to the owning requester. Sits between requester logic (or testcase drivers) and `memory_ctrl`; `memory_core` is untouched.

---
 rtl/memory_arb_pkg.sv | 26 ++
 rtl/memory_arbiter_rr_pick.sv | 37 +++
 rtl/memory_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/memory_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_arb_pkg                                                             |
// | Shared types for the memory_ctrl command-port arbiter.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package memory_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // One requester command at the default port widths.
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Round-robin search: first valid index after last_i, wrapping to 0.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W-1:0] w_cand;

  // Offset NUM_REQ lands back on last_i, so it is considered last.
  always_comb begin
    pick_o  = '0;
    idx_o   = '0;
    found_o = 1'b0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
      if (!found_o && valid_i[w_cand]) begin
        found_o        = 1'b1;
        pick_o[w_cand] = 1'b1;
        idx_o          = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_arbiter                                                             |
// | Round-robin sharing of the memory_ctrl system command port.                |
// | Define MEM_ARB_TIMEOUT_EN to build the WAIT-state watchdog.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_arbiter
  import memory_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      cmd_valid_sys,
  output logic                      we_sys,
  output logic [ADDR_W-1:0]         addr_sys,
  output logic [DATA_W-1:0]         wdata_sys,
  input  logic [DATA_W-1:0]         rdata_sys,
  input  logic                      ready_sys
);

  localparam int c_IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_param_check
    $error("memory_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 2");
  end

  arb_state_e          state_q;
  logic [c_IDX_W-1:0]  owner_q;
  logic [c_IDX_W-1:0]  last_grant_q;
  logic [NUM_REQ-1:0]  owner_oh_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                cmd_valid_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [c_IDX_W-1:0]  w_pick_idx;
  logic                w_found;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_pick (
    .valid_i (req_valid),
    .last_i  (last_grant_q),
    .pick_o  (w_pick_oh),
    .idx_o   (w_pick_idx),
    .found_o (w_found)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [c_CNT_W-1:0] wd_cnt_q;
  logic [NUM_REQ-1:0] err_q;
  logic               w_expired;

  assign w_expired = (wd_cnt_q == c_CNT_W'(TIMEOUT - 1));
  assign req_err   = err_q;
`else
  assign req_err   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= c_IDX_W'(NUM_REQ - 1);
      owner_oh_q   <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      cmd_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wd_cnt_q     <= '0;
      err_q        <= '0;
`endif
    end else begin
      grant_q     <= '0;
      done_q      <= '0;
      cmd_valid_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q       <= '0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (w_found) begin
            owner_q     <= w_pick_idx;
            owner_oh_q  <= w_pick_oh;
            we_q        <= req_we[w_pick_idx];
            addr_q      <= req_addr[w_pick_idx*ADDR_W +: ADDR_W];
            wdata_q     <= req_wdata[w_pick_idx*DATA_W +: DATA_W];
            grant_q     <= w_pick_oh;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          last_grant_q <= owner_q;
          state_q      <= ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          wd_cnt_q     <= '0;
`endif
        end
        ST_WAIT: begin
          // A ready in the expiry cycle still completes normally.
          if (ready_sys) begin
            rdata_q <= rdata_sys;
            done_q  <= owner_oh_q;
            state_q <= ST_IDLE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (w_expired) begin
            rdata_q <= '1;
            done_q  <= owner_oh_q;
            err_q   <= owner_oh_q;
            state_q <= ST_IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_grant     = grant_q;
  assign req_done      = done_q;
  assign req_rdata     = rdata_q;
  assign cmd_valid_sys = cmd_valid_q;
  assign we_sys        = we_q;
  assign addr_sys      = addr_q;
  assign wdata_sys     = wdata_q;

endmodule
`default_nettype wire
